// File: rtl/auth_request_decoder_pkg.sv
// Shared message codes, error codes, sizes and state encodings for the
// USB Type-C Authentication request decoder.
package auth_request_decoder_pkg;

  localparam int unsigned SIZE_OF_HEADER = 4;

  localparam logic [7:0] PROTOCOL_VERSION    = 8'h01;

  localparam logic [7:0] MSG_GET_DIGESTS     = 8'h81;
  localparam logic [7:0] MSG_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] MSG_CHALLENGE       = 8'h83;
  localparam logic [7:0] MSG_DIGESTS         = 8'h01;
  localparam logic [7:0] MSG_CERTIFICATE     = 8'h02;
  localparam logic [7:0] MSG_CHALLENGE_AUTH  = 8'h03;
  localparam logic [7:0] MSG_ERROR           = 8'h7F;

  localparam logic [7:0] ERR_NONE                 = 8'h00;
  localparam logic [7:0] ERR_INVALID_REQUEST      = 8'h01;
  localparam logic [7:0] ERR_UNSUPPORTED_PROTOCOL = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_DISCARD  = 3'd3,
    ST_WAIT_ACK = 3'd4
  } state_e;

  typedef enum logic {
    REQ_CHALLENGE = 1'b0,
    REQ_CERT      = 1'b1
  } req_kind_e;

endpackage

// File: rtl/auth_request_decoder.sv
// Parses Authentication request bytes into header/payload fields and raises one
// held enable (challenge, digests, certificate or error) until the responder acks.
module auth_request_decoder
  import auth_request_decoder_pkg::*;
#(
  parameter int unsigned NONCE_BYTES    = 32,
  parameter int unsigned CERT_REQ_BYTES = 4,
  parameter int unsigned ACK_TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_last,
  output logic                     rx_ready,
  input  logic                     ack_in,
  output logic [31:0]              header_out,
  output logic [7:0]               slot_out,
  output logic [8*NONCE_BYTES-1:0] nonce_out,
  output logic [15:0]              cert_offset,
  output logic [15:0]              cert_length,
  output logic                     challenge_en,
  output logic                     digests_en,
  output logic                     cert_en,
  output logic                     error_en,
  output logic [7:0]               error_code,
  output logic                     timeout_flag
);

  localparam int unsigned NONCE_W = 8 * NONCE_BYTES;
  localparam int unsigned TW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [5:0]  HDR_LAST   = 6'(SIZE_OF_HEADER - 1);
  localparam logic [5:0]  NONCE_LAST = 6'(NONCE_BYTES - 1);
  localparam logic [5:0]  CERT_LAST  = 6'(CERT_REQ_BYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  req_kind_e           kind_q, kind_d;
  logic [5:0]          byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NONCE_W-9:0]  shadow_q, shadow_d;
  logic [7:0]          err_latch_q, err_latch_d;
  logic [31:0]         header_q, header_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [15:0]         cert_offset_q, cert_offset_d;
  logic [15:0]         cert_length_q, cert_length_d;
  logic                rx_ready_q, rx_ready_d;
  logic                challenge_en_q, challenge_en_d;
  logic                digests_en_q, digests_en_d;
  logic                cert_en_q, cert_en_d;
  logic                error_en_q, error_en_d;
  logic [7:0]          error_code_q, error_code_d;
  logic                timeout_flag_q, timeout_flag_d;

  logic                accept_s;
  logic [NONCE_W-1:0]  shift_s;
  logic [5:0]          last_idx_s;
  logic                fail_now_s;
  logic                fail_later_s;
  logic [7:0]          fail_code_s;

  assign accept_s   = rx_valid && rx_ready_q;
  // The newest byte lands in the LSBs, so the first nonce byte ends up in the MSBs.
  assign shift_s    = {shadow_q, rx_data};
  assign last_idx_s = (kind_q == REQ_CHALLENGE) ? NONCE_LAST : CERT_LAST;

  // Next-state and registered-output computation for the request parser.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    byte_cnt_d     = byte_cnt_q;
    timer_d        = timer_q;
    shadow_d       = shadow_q;
    err_latch_d    = err_latch_q;
    header_d       = header_q;
    nonce_d        = nonce_q;
    cert_offset_d  = cert_offset_q;
    cert_length_d  = cert_length_q;
    challenge_en_d = challenge_en_q;
    digests_en_d   = digests_en_q;
    cert_en_d      = cert_en_q;
    error_en_d     = error_en_q;
    error_code_d   = error_code_q;
    timeout_flag_d = 1'b0;
    fail_now_s     = 1'b0;
    fail_later_s   = 1'b0;
    fail_code_s    = ERR_INVALID_REQUEST;

    case (state_q)
      ST_IDLE: state_d = ST_HDR;
      ST_HDR: begin
        if (accept_s) begin
          case (byte_cnt_q[1:0])
            2'd0:    header_d[31:24] = rx_data;
            2'd1:    header_d[23:16] = rx_data;
            2'd2:    header_d[15:8]  = rx_data;
            default: header_d[7:0]   = rx_data;
          endcase
          if (byte_cnt_q != HDR_LAST) begin
            if (rx_last) fail_now_s = 1'b1;
            else         byte_cnt_d = byte_cnt_q + 6'd1;
          end else if (header_q[31:24] != PROTOCOL_VERSION) begin
            fail_code_s  = ERR_UNSUPPORTED_PROTOCOL;
            fail_now_s   = rx_last;
            fail_later_s = !rx_last;
          end else begin
            case (header_q[23:16])
              MSG_GET_DIGESTS: begin
                if (rx_last) begin
                  digests_en_d = 1'b1;
                  error_code_d = ERR_NONE;
                  byte_cnt_d   = 6'd0;
                  state_d      = ST_WAIT_ACK;
                end else begin
                  fail_later_s = 1'b1;
                end
              end
              MSG_CHALLENGE, MSG_GET_CERTIFICATE: begin
                if (rx_last) begin
                  fail_now_s = 1'b1;
                end else begin
                  kind_d     = (header_q[23:16] == MSG_CHALLENGE) ? REQ_CHALLENGE : REQ_CERT;
                  byte_cnt_d = 6'd0;
                  state_d    = ST_PAYLOAD;
                end
              end
              default: begin
                fail_now_s   = rx_last;
                fail_later_s = !rx_last;
              end
            endcase
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          shadow_d = shift_s[NONCE_W-9:0];
          if (byte_cnt_q == last_idx_s) begin
            byte_cnt_d = 6'd0;
            if (rx_last) begin
              error_code_d = ERR_NONE;
              state_d      = ST_WAIT_ACK;
              if (kind_q == REQ_CHALLENGE) begin
                nonce_d        = shift_s;
                challenge_en_d = 1'b1;
              end else begin
                // Offset and length arrive little-endian on the wire.
                cert_offset_d = {shift_s[23:16], shift_s[31:24]};
                cert_length_d = {shift_s[7:0], shift_s[15:8]};
                cert_en_d     = 1'b1;
              end
            end else begin
              fail_later_s = 1'b1;
            end
          end else if (rx_last) begin
            fail_now_s = 1'b1;
          end else if (byte_cnt_q != 6'h3F) begin
            byte_cnt_d = byte_cnt_q + 6'd1;
          end else begin
            byte_cnt_d = byte_cnt_q;
          end
        end else begin
          shadow_d = shadow_q;
        end
      end
      ST_DISCARD: begin
        if (accept_s && rx_last) begin
          fail_now_s  = 1'b1;
          fail_code_s = err_latch_q;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_in || (timer_q == TIMER_LAST)) begin
          timeout_flag_d = !ack_in;
          challenge_en_d = 1'b0;
          digests_en_d   = 1'b0;
          cert_en_d      = 1'b0;
          error_en_d     = 1'b0;
          timer_d        = '0;
          state_d        = ST_HDR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail_now_s) begin
      error_en_d   = 1'b1;
      error_code_d = fail_code_s;
      byte_cnt_d   = 6'd0;
      timer_d      = '0;
      state_d      = ST_WAIT_ACK;
    end else if (fail_later_s) begin
      err_latch_d = fail_code_s;
      byte_cnt_d  = 6'd0;
      state_d     = ST_DISCARD;
    end else begin
      err_latch_d = err_latch_q;
    end

    rx_ready_d = (state_d == ST_HDR) || (state_d == ST_PAYLOAD) || (state_d == ST_DISCARD);
  end

  // State, counters and output registers; reset drops any partial request.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q        <= ST_IDLE;
      kind_q         <= REQ_CHALLENGE;
      byte_cnt_q     <= 6'd0;
      timer_q        <= '0;
      shadow_q       <= '0;
      err_latch_q    <= 8'h00;
      header_q       <= 32'h0;
      nonce_q        <= '0;
      cert_offset_q  <= 16'h0;
      cert_length_q  <= 16'h0;
      rx_ready_q     <= 1'b0;
      challenge_en_q <= 1'b0;
      digests_en_q   <= 1'b0;
      cert_en_q      <= 1'b0;
      error_en_q     <= 1'b0;
      error_code_q   <= 8'h00;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      byte_cnt_q     <= byte_cnt_d;
      timer_q        <= timer_d;
      shadow_q       <= shadow_d;
      err_latch_q    <= err_latch_d;
      header_q       <= header_d;
      nonce_q        <= nonce_d;
      cert_offset_q  <= cert_offset_d;
      cert_length_q  <= cert_length_d;
      rx_ready_q     <= rx_ready_d;
      challenge_en_q <= challenge_en_d;
      digests_en_q   <= digests_en_d;
      cert_en_q      <= cert_en_d;
      error_en_q     <= error_en_d;
      error_code_q   <= error_code_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign header_out   = header_q;
  assign slot_out     = header_q[15:8];
  assign nonce_out    = nonce_q;
  assign cert_offset  = cert_offset_q;
  assign cert_length  = cert_length_q;
  assign challenge_en = challenge_en_q;
  assign digests_en   = digests_en_q;
  assign cert_en      = cert_en_q;
  assign error_en     = error_en_q;
  assign error_code   = error_code_q;
  assign timeout_flag = timeout_flag_q;

endmodule
